// File: rtl/ctx_regfile_if.sv
// Register-file access and context-stack control/status bundle.
// master drives writes, reads and context ops; slave is the register file.
interface ctx_regfile_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int CTX_DEPTH = 4
);
  localparam int LVL_W = $clog2(CTX_DEPTH + 1);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [1:0]        ctx_op;
  logic [LVL_W-1:0]  ctx_level;
  logic              ctx_full;
  logic              ctx_empty;
  logic              ctx_err;
  logic              err_clr;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, ctx_op, err_clr,
    input  rdata1, rdata2, ctx_level, ctx_full, ctx_empty, ctx_err
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, ctx_op, err_clr,
    output rdata1, rdata2, ctx_level, ctx_full, ctx_empty, ctx_err
  );
endinterface

// File: rtl/ctx_regfile.sv
// Register file with a stack of shadow banks for nested save/restore; all ops take one cycle.
// Reads are combinational; no backpressure, out-of-range stack ops are dropped and flagged in ctx_err.
module ctx_regfile #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int CTX_DEPTH = 4,
  parameter bit BYPASS    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  ctx_regfile_if.slave bus
);
  localparam int NREG    = 1 << ADDR_W;
  localparam int LVL_W   = $clog2(CTX_DEPTH + 1);
  localparam int BANK_AW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

  localparam logic [1:0] OP_SAVE = 2'b01;
  localparam logic [1:0] OP_REST = 2'b11;
  localparam logic [1:0] OP_DISC = 2'b10;

  logic [DATA_W-1:0] live [NREG];
  logic [DATA_W-1:0] bank [CTX_DEPTH][NREG];

  logic [LVL_W-1:0]   sp;
  logic [LVL_W-1:0]   sp_dec;
  logic [BANK_AW-1:0] wsel;
  logic [BANK_AW-1:0] rsel;
  logic               full;
  logic               empty;
  logic               do_save;
  logic               do_rest;
  logic               do_disc;
  logic               ovf;
  logic               unf;
  logic               err_q;
  logic [DATA_W-1:0]  rd1_raw;
  logic [DATA_W-1:0]  rd2_raw;

  assign full   = (sp == LVL_W'(CTX_DEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - LVL_W'(1);
  assign wsel   = sp[BANK_AW-1:0];
  assign rsel   = sp_dec[BANK_AW-1:0];

  assign do_save = (bus.ctx_op == OP_SAVE) && !full;
  assign do_rest = (bus.ctx_op == OP_REST) && !empty;
  assign do_disc = (bus.ctx_op == OP_DISC) && !empty;
  assign ovf     = (bus.ctx_op == OP_SAVE) && full;
  assign unf     = ((bus.ctx_op == OP_REST) || (bus.ctx_op == OP_DISC)) && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (do_save) begin
      sp <= sp + LVL_W'(1);
    end else if (do_rest || do_disc) begin
      sp <= sp_dec;
    end
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (ovf || unf) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  // Snapshot uses pre-edge live values, so a same-cycle write never enters it.
  always_ff @(posedge clk) begin
    if (!rst && do_save) begin
      for (int i = 0; i < NREG; i++) begin
        bank[wsel][i] <= live[i];
      end
    end
  end

  // Register 0 is only ever reset; restore skips it and the write path drops address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        live[i] <= '0;
      end
    end else begin
      if (do_rest) begin
        for (int i = 1; i < NREG; i++) begin
          live[i] <= bank[rsel][i];
        end
      end
      if (bus.we && (bus.waddr != '0)) begin
        live[bus.waddr] <= bus.wdata;
      end
    end
  end

  assign rd1_raw = (bus.raddr1 == '0) ? '0 : live[bus.raddr1];
  assign rd2_raw = (bus.raddr2 == '0) ? '0 : live[bus.raddr2];

  always_comb begin
    bus.rdata1 = rd1_raw;
    bus.rdata2 = rd2_raw;
    if (BYPASS) begin
      if (bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end
      if (bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end
    end
  end

  assign bus.ctx_level = sp;
  assign bus.ctx_full  = full;
  assign bus.ctx_empty = empty;
  assign bus.ctx_err   = err_q;
endmodule

// File: tb/tb_ctx_regfile.sv
// Directed bench: default-configured file with bypass, plus a narrow
// (16-bit data, 8 registers, 2 contexts) instance without bypass.
module tb_ctx_regfile;
  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] SAVE = 2'b01;
  localparam logic [1:0] REST = 2'b11;
  localparam logic [1:0] DISC = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ctx_regfile_if #(.DATA_W(32), .ADDR_W(5), .CTX_DEPTH(4)) b0 ();
  ctx_regfile_if #(.DATA_W(16), .ADDR_W(3), .CTX_DEPTH(2)) b1 ();

  ctx_regfile #(.DATA_W(32), .ADDR_W(5), .CTX_DEPTH(4), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  ctx_regfile #(.DATA_W(16), .ADDR_W(3), .CTX_DEPTH(2), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clocked operation on instance 0, inputs returned to idle afterwards.
  task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d,
                    input logic [1:0] o, input logic clr);
    b0.we = w; b0.waddr = a; b0.wdata = d; b0.ctx_op = o; b0.err_clr = clr;
    cyc();
    b0.we = 1'b0; b0.ctx_op = NONE; b0.err_clr = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    op(1'b1, a, d, NONE, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    b0.raddr1 = a; b0.raddr2 = a;
    #1;
    chk({tag, ".p1"}, b0.rdata1, exp);
    chk({tag, ".p2"}, b0.rdata2, exp);
  endtask

  initial begin
    b0.we = 0; b0.waddr = 0; b0.wdata = 0; b0.raddr1 = 0; b0.raddr2 = 0;
    b0.ctx_op = NONE; b0.err_clr = 0;
    b1.we = 0; b1.waddr = 0; b1.wdata = 0; b1.raddr1 = 0; b1.raddr2 = 0;
    b1.ctx_op = NONE; b1.err_clr = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    chk("rst_level", b0.ctx_level, 0);
    chk("rst_empty", b0.ctx_empty, 1);
    chk("rst_full", b0.ctx_full, 0);
    chk("rst_err", b0.ctx_err, 0);
    rd("rst_r5", 5, 0);

    // Asynchronous reset in mid-cycle with live and stack state present
    wr(5, 32'h1234);
    op(0, 0, 0, SAVE, 0);
    chk("pre_rst_level", b0.ctx_level, 1);
    rd("pre_rst_r5", 5, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_r5", b0.rdata1, 0);
    chk("async_rst_empty", b0.ctx_empty, 1);
    chk("async_rst_level", b0.ctx_level, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Register 0 stays zero, including through the bypass path
    b0.we = 1; b0.waddr = 0; b0.wdata = 32'hFFFF; b0.raddr1 = 0;
    #1 chk("r0_bypass", b0.rdata1, 0);
    cyc();
    b0.we = 0;
    rd("r0_after_wr", 0, 0);

    // Nested save/restore
    wr(1, 32'hA);
    op(0, 0, 0, SAVE, 0);
    wr(1, 32'hB);
    op(0, 0, 0, SAVE, 0);
    wr(1, 32'hC);
    chk("nest_level2", b0.ctx_level, 2);
    rd("nest_r1_C", 1, 32'hC);
    op(0, 0, 0, REST, 0);
    rd("nest_r1_B", 1, 32'hB);
    chk("nest_level1", b0.ctx_level, 1);
    op(0, 0, 0, REST, 0);
    rd("nest_r1_A", 1, 32'hA);
    chk("nest_empty", b0.ctx_empty, 1);
    chk("nest_err", b0.ctx_err, 0);

    // Write concurrent with save and with restore
    wr(2, 32'h5);
    op(1, 2, 32'h9, SAVE, 0);
    rd("sim_save_r2", 2, 32'h9);
    chk("sim_save_level", b0.ctx_level, 1);
    op(1, 3, 32'h7, REST, 0);
    rd("sim_rest_r2", 2, 32'h5);
    rd("sim_rest_r3", 3, 32'h7);
    chk("sim_rest_level", b0.ctx_level, 0);

    // Overflow at depth 4; bank 3 must hold the fourth snapshot
    wr(7, 32'h1); op(0, 0, 0, SAVE, 0);
    wr(7, 32'h2); op(0, 0, 0, SAVE, 0);
    wr(7, 32'h3); op(0, 0, 0, SAVE, 0);
    wr(7, 32'h4); op(0, 0, 0, SAVE, 0);
    op(1, 7, 32'h5, SAVE, 0);
    chk("ovf_level", b0.ctx_level, 4);
    chk("ovf_full", b0.ctx_full, 1);
    chk("ovf_err", b0.ctx_err, 1);
    rd("ovf_wr_r7", 7, 32'h5);
    op(0, 0, 0, REST, 0);
    rd("ovf_bank3_r7", 7, 32'h4);
    chk("ovf_level3", b0.ctx_level, 3);
    chk("err_sticky", b0.ctx_err, 1);
    op(0, 0, 0, NONE, 1);
    chk("err_clr", b0.ctx_err, 0);
    op(0, 0, 0, REST, 0);
    op(0, 0, 0, REST, 0);
    op(0, 0, 0, REST, 0);
    rd("drain_r7", 7, 32'h1);
    chk("drain_empty", b0.ctx_empty, 1);

    // Underflow with simultaneous clear and write: set wins, write lands
    op(1, 8, 32'h33, REST, 1);
    chk("unf_err_set_wins", b0.ctx_err, 1);
    chk("unf_level", b0.ctx_level, 0);
    rd("unf_wr_r8", 8, 32'h33);
    rd("unf_r7_kept", 7, 32'h1);
    op(0, 0, 0, NONE, 1);
    chk("unf_clr", b0.ctx_err, 0);
    op(0, 0, 0, DISC, 0);
    chk("disc_unf_err", b0.ctx_err, 1);
    op(0, 0, 0, NONE, 1);

    // Discard keeps the live file
    wr(4, 32'h11);
    op(0, 0, 0, SAVE, 0);
    wr(4, 32'h22);
    op(0, 0, 0, DISC, 0);
    rd("disc_r4", 4, 32'h22);
    chk("disc_level", b0.ctx_level, 0);
    chk("disc_err", b0.ctx_err, 0);

    // Bypass on instance 0
    b0.raddr1 = 6; b0.raddr2 = 6;
    b0.we = 1; b0.waddr = 6; b0.wdata = 32'hDEAD;
    #1;
    chk("byp_p1", b0.rdata1, 32'hDEAD);
    chk("byp_p2", b0.rdata2, 32'hDEAD);
    cyc();
    b0.we = 0;
    rd("byp_stored", 6, 32'hDEAD);
    // Reads show pre-edge live values during a restore
    op(0, 0, 0, SAVE, 0);
    wr(6, 32'hBEEF);
    b0.ctx_op = REST; b0.raddr1 = 6;
    #1 chk("rest_no_lookthrough", b0.rdata1, 32'hBEEF);
    cyc();
    b0.ctx_op = NONE;
    rd("rest_r6", 6, 32'hDEAD);

    // Narrow instance, bypass disabled
    b1.raddr1 = 6; b1.raddr2 = 6;
    b1.we = 1; b1.waddr = 6; b1.wdata = 16'hBEEF;
    #1;
    chk("nobyp_old_p1", b1.rdata1, 0);
    chk("nobyp_old_p2", b1.rdata2, 0);
    cyc();
    b1.we = 0;
    #1;
    chk("nobyp_new_p1", b1.rdata1, 32'hBEEF);
    b1.we = 1; b1.waddr = 0; b1.wdata = 16'hFFFF; b1.raddr1 = 0;
    cyc();
    b1.we = 0;
    #1 chk("n_r0", b1.rdata1, 0);
    b1.ctx_op = SAVE;
    cyc(); cyc(); cyc();
    b1.ctx_op = NONE;
    chk("n_ovf_level", b1.ctx_level, 2);
    chk("n_ovf_full", b1.ctx_full, 1);
    chk("n_ovf_err", b1.ctx_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctx_regfile.md
Name: ctx_regfile

Overview:
- Parametrised general-purpose register file with a hardware context stack of shadow banks.
- Supports nested save/restore: interrupt or exception entry pushes the live file, and return pops it.
- Sits in the datapath in the same place as the single-shadow register file it replaces.
- Adds depth, width and nesting parameters, stack occupancy/error status, discard, optional write-to-read bypass, and asynchronous reset.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W registers.
- CTX_DEPTH, 4, number of shadow contexts in the stack (>=1).
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0, reads return stored values only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable for the live file.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data (combinational).
- ctx_op  in  2  context operation: 00 none, 01 save (push), 11 restore (pop into live), 10 discard (pop, live unchanged).
- ctx_level  out  clog2(CTX_DEPTH+1)  number of contexts currently stored.
- ctx_full  out  1  ctx_level == CTX_DEPTH.
- ctx_empty  out  1  ctx_level == 0.
- ctx_err  out  1  sticky overflow/underflow flag.
- err_clr  in  1  clears ctx_err.

Behaviour:
- Reset (asynchronous, takes effect immediately): all live registers are 0, stack pointer is 0, ctx_err is 0.
  - After reset: ctx_empty=1, ctx_full=0, ctx_level=0, rdata1=rdata2=0.
  - Shadow bank contents are don't-care after reset; they are never readable before a save.
  - Reset asserted mid-operation aborts any pending save/restore; no partial state survives.
- Register 0 reads as 0 always. Writes to address 0 are dropped. A restore never makes register 0 nonzero.
- Reads are combinational from the live file.
  - BYPASS=1: if we=1, waddr==raddrN and waddr!=0, then rdataN=wdata in the same cycle.
  - Bypass does not look through a same-cycle restore; reads show pre-edge live values.
- Save (01), if not full: at the edge, bank[sp] captures the live file values from before that edge, then sp increments.
  - A same-cycle write does not enter the snapshot; it does land in the live file.
- Restore (11), if not empty: at the edge, the live file loads bank[sp-1], then sp decrements.
  - If we=1 in the same cycle, the write is applied after the restore, so live[waddr]=wdata.
- Discard (10), if not empty: sp decrements only. Any write proceeds normally.
- Overflow: save while full is ignored (sp and banks unchanged) and sets ctx_err. The write still proceeds.
- Underflow: restore or discard while empty is ignored and sets ctx_err. The live file is unchanged except for the write.
- err_clr=1 clears ctx_err at the edge. If a new error occurs in the same cycle, set wins and ctx_err stays 1.
- Single-cycle latency for all operations: ctx_level, ctx_full and ctx_empty are registered-derived and update on the edge after the op.
- Pointer arithmetic is saturating by construction: sp never exceeds CTX_DEPTH and never goes below 0. There is no wrap-around.

Test Plan:
- Reset/zero: assert rst mid-cycle with r5=0x1234 -> rdata=0 immediately; ctx_empty=1, ctx_level=0. Write r0=0xFFFF -> read r0=0.
- Nested save/restore:
  - Write r1=0xA, save; r1=0xB, save; r1=0xC -> ctx_level=2.
  - Restore -> r1=0xB; restore -> r1=0xA; ctx_empty=1, ctx_err=0.
- Simultaneous ops:
  - With r2=0x5, issue save plus write r2=0x9 -> live r2=0x9.
  - Then restore plus write r3=0x7 -> r2=0x5, r3=0x7 (write wins over restored value).
- Overflow/underflow:
  - CTX_DEPTH=4: five saves -> ctx_level=4, ctx_full=1, ctx_err=1, bank 3 holds the 4th snapshot.
  - err_clr -> ctx_err=0.
  - Restore on empty with err_clr in the same cycle -> ctx_err=1.
- Discard: save with r4=0x11, write r4=0x22, discard -> r4=0x22, ctx_level=0.
- Bypass: BYPASS=1, write r6=0xDEAD with raddr1=6 -> rdata1=0xDEAD in the same cycle. With BYPASS=0 -> old value until the next cycle. Also run with DATA_W=16, ADDR_W=3.
